shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential unsigned shift-and-add multiplier: radix-2, one multiplier bit per clock.
//  Inverse companion of the team's sequential restoring divider.
//  Dividend = p, divisor = a, expected quotient = b (remainder 0) closes the arithmetic loop.
//  Sits beside the divider in the arithmetic datapath; a start/busy/done handshake sequences it.
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range 2..32; product is 2*WIDTH bits
// PORTS
//  clk    in   1        rising-edge clock; single clock domain
//  rst_n  in   1        synchronous reset, active-low
//  start  in   1        request; sampled on rising clk, accepted only in IDLE or DONE
//  a      in   WIDTH    multiplicand; captured on accepted start
//  b      in   WIDTH    multiplier; captured on accepted start
//  p      out  2*WIDTH  product register; holds last result until next completion
//  busy   out  1        high while an operation is in progress (RUN)
//  done   out  1        one-cycle pulse; p is valid in the same cycle
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low.
//  Reset (rst_n=0 at a clk edge): state=IDLE, p=0, busy=0, done=0, count=0, internal regs=0.
//  Reset mid-operation: the operation is abandoned; no done pulse; p reads 0.
//  States:
//   IDLE --start--> RUN
//   RUN --count==WIDTH-1--> DONE
//   DONE --start--> RUN
//   DONE --no start--> IDLE
//  Load (accepted start at edge t0):
//   mcand<=a, acc<={WIDTH'0, b}, count<=0, busy<=1, done<=0.
//  Iteration (each edge while RUN):
//   sum = acc[2W-1:W] + (acc[0] ? mcand : 0), computed WIDTH+1 bits wide (carry kept).
//   acc <= {sum, acc[W-1:1]}, i.e. the carry shifts into the MSB; count++.
//  Completion:
//   Edge t0+WIDTH performs the last iteration; p<=final acc, busy<=0, done<=1, state=DONE.
//   Latency start->done = WIDTH cycles; for WIDTH=8, done is high after edge t0+8.
//   Edge t0+WIDTH+1: done<=0.
//   Back-to-back: a start seen in DONE reloads immediately, so throughput is 1 op per WIDTH+1 cycles.
//  start while RUN: ignored; operands are not re-sampled; a/b may change freely while busy.
//  start held high continuously: a new operation begins every WIDTH+1 cycles.
//  Width rules: no truncation; the max product (2^W-1)^2 fits in 2W bits; operands are unsigned only.
//  Zero operand: still takes the full WIDTH cycles; p=0. No early termination.
//  count is $clog2(WIDTH) bits wide and must not wrap before WIDTH-1 is reached.
//  Outputs are registered only; no combinational path from start/a/b to p/busy/done.
// STRUCTURE
//  Package arith_pkg holds:
//   - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is unreachable and decodes to IDLE.
//   - shared handshake constants, reused by the divider.
//  Optional sub-module mul_step: combinational single iteration, (acc, mcand) -> next acc.
//  The top module holds the FSM, the counter and the registers.
// TESTING
//  1. WIDTH=8, reset 2 cycles, a=13 b=11 start 1 cycle -> busy 8 cycles; done 1 cycle; p=16'h008F (143).
//  2. a=255 b=255 -> p=16'hFE01 (65025); checks the carry path into the MSB.
//  3. a=0 b=200, then a=200 b=0 -> p=0 both times; done still arrives exactly 8 cycles after start.
//  4. a=6 b=7, start re-pulsed at cycle 3 with a=1 b=1 -> ignored; p=42; only one done pulse.
//  5. Start a=9 b=9; rst_n=0 at cycle 4 -> p=0, busy=0; no done; next op a=3 b=5 -> p=15.
//  6. start held high, operand pairs (2,3),(4,5),(250,4) -> done every 9 cycles; p=6,20,1000.
//  Also: random 1000 ops vs a*b; p fed to the divider with divisor a -> quotient b.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: sequencer state
// encoding and start/busy/done handshake levels.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic HS_ON  = 1'b1;
  localparam logic HS_OFF = 1'b0;

  // Any state other than RUN (including the unused code) takes a start.
  function automatic logic can_accept(input logic [1:0] st);
    return st != ST_RUN;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-and-add iteration: conditional add of the
// multiplicand into the upper half, then shift right with carry.
module mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  assign w_addend = i_acc[0] ? {1'b0, i_mcand} : '0;
  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + w_addend;
  assign o_acc    = {w_sum, i_acc[WIDTH-1:1]};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit
// per clock, with a start/busy/done handshake.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_p;
  logic               r_busy;
  logic               r_done;

  logic [2*WIDTH-1:0] w_next_acc;
  logic               w_last;

  mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_acc  (r_acc),
    .i_mcand(r_mcand),
    .o_acc  (w_next_acc)
  );

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_p     <= '0;
      r_busy  <= HS_OFF;
      r_done  <= HS_OFF;
    end else begin
      r_done <= HS_OFF;
      case (r_state)
        ST_RUN: begin
          r_acc   <= w_next_acc;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_p     <= w_next_acc;
            r_busy  <= HS_OFF;
            r_done  <= HS_ON;
            r_state <= ST_DONE;
          end
        end
        default: begin
          // IDLE, DONE and the unused code all behave as IDLE here
          if (start && can_accept(r_state)) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_count <= '0;
            r_busy  <= HS_ON;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign p    = r_p;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=8): vector
// table, hand-written corner sequences and random ops vs a*b.
module tb_shift_add_multiplier;

  localparam int W   = 8;
  localparam int LAT = W;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;

  int errors;
  int checks;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[8];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .p    (p),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one op; returns edges from the accepting edge to done and p.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int lat, output logic [2*W-1:0] pv);
    a = ia;
    b = ib;
    start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (!done && busy !== 1'b1) check("busy_while_run", busy, 1);
    end
    pv = p;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input int lat,
                          input logic [2*W-1:0] pv);
    int prod;
    prod = int'(ia) * int'(ib);
    check({name, "_latency"}, lat, LAT);
    check({name, "_p"}, pv, prod);
    check({name, "_busy_at_done"}, busy, 0);
    if (ia != 0) begin
      check({name, "_div_quot"}, int'(pv) / int'(ia), ib);
      check({name, "_div_rem"}, int'(pv) % int'(ia), 0);
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int gap;
    logic [2*W-1:0] pv;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    errors = 0;
    checks = 0;
    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   16'h0000};
    vecs[4] = '{8'd1,   8'd1,   16'h0001};
    vecs[5] = '{8'd128, 8'd2,   16'h0100};
    vecs[6] = '{8'd255, 8'd1,   16'h00FF};
    vecs[7] = '{8'd17,  8'd15,  16'h00FF};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("reset_p", p, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, pv);
      check("vec_latency", lat, LAT);
      check("vec_p", pv, vecs[i].p);
      step();
      check("vec_done_pulse", done, 0);
      check("vec_p_hold", p, vecs[i].p);
    end

    // start re-pulsed while running must be ignored
    a = 8'd6;
    b = 8'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c < 14; c++) begin
      if (c == 3) begin
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        ndone++;
        check("ignore_p", p, 42);
        check("ignore_latency", c, LAT);
      end
    end
    start = 1'b0;
    check("ignore_one_done", ndone, 1);

    // reset mid-operation abandons the op
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_p", p, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(8'd3, 8'd5, lat, pv);
    check_op("after_rst", 8'd3, 8'd5, lat, pv);
    step();

    // start held high: one op every W+1 cycles
    start = 1'b1;
    a = 8'd2;
    b = 8'd3;
    step();
    a = 8'd4;
    b = 8'd5;
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    check("held0_latency", lat, LAT);
    check("held0_p", p, 6);
    foreach (vecs[k]) begin
      if (k < 2) begin
        gap = 0;
        do begin
          step();
          gap++;
          if (gap == 2) begin
            a = 8'd250;
            b = 8'd4;
          end
        end while (!done && gap < 40);
        check("held_gap", gap, LAT + 1);
        check("held_p", p, (k == 0) ? 20 : 1000);
      end
    end
    start = 1'b0;
    step();
    check("held_stop_busy", busy, 0);
    step();

    // random ops against plain multiplication
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 50 == 0) ra = '0;
      if (n % 50 == 1) rb = W'(255);
      run_op(ra, rb, lat, pv);
      check_op("rand", ra, rb, lat, pv);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
